// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives the select of an 8:1 mux. The owner keeps the path for up to
// MAX_HOLD cycles; on release the next owner is chosen in the same cycle, so there is no idle gap.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [3:0] hold_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] gnt_nxt;
  logic [3:0] hold_nxt;
  logic [2:0] search_base;
  logic [3:0] win;
  logic       owner_req;
  logic       release_ev;

  // Returns {found, index} of the first set request at or after base, wrapping modulo 8.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      k = base + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      gnt       <= 8'd0;
      gnt_valid <= 1'b0;
      hold_cnt  <= 4'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  // A release searches from the slot after the outgoing owner; idle arbitration uses ptr.
  always_comb begin
    owner_req   = req[sel];
    release_ev  = (state == GRANT) && (!owner_req || (hold_cnt == HOLD_LAST));
    search_base = (state == GRANT) ? sel + 3'd1 : ptr;
    win         = pick(req, search_base);
    ptr_nxt     = release_ev ? sel + 3'd1 : ptr;
    state_nxt   = state;
    case (state)
      IDLE:    if (win[3]) state_nxt = GRANT;
      GRANT:   if (release_ev && !win[3]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt  = sel;
    gnt_nxt  = gnt;
    hold_nxt = hold_cnt;
    if ((state == IDLE) || release_ev) begin
      hold_nxt = 4'd0;
      if (win[3]) begin
        sel_nxt = win[2:0];
        gnt_nxt = 8'd1 << win[2:0];
      end else begin
        gnt_nxt = 8'd0;
      end
    end else begin
      hold_nxt = hold_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: two instances (MAX_HOLD 4 and 1) share one request bus and
// are compared against an owner/held-cycles reference model.
module tb_mux_sel_arbiter;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gv;
    logic [3:0] hold;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] sel0, sel1;
  logic [7:0] gnt0, gnt1;
  logic       gv0, gv1;
  logic [3:0] hc0, hc1;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: owner index (-1 none), cycles held so far, search start, last owner.
  int owner[2];
  int held[2];
  int ptr[2];
  int last[2];
  int mh[2];

  mux_sel_arbiter #(.MAX_HOLD(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel0), .gnt(gnt0), .gnt_valid(gv0), .hold_cnt(hc0)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel1), .gnt(gnt1), .gnt_valid(gv1), .hold_cnt(hc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic int first_req(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      held[i]  = 0;
      ptr[i]   = 0;
      last[i]  = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic [7:0] r);
    int w;
    if (owner[i] < 0) begin
      w = first_req(r, ptr[i]);
      if (w >= 0) begin
        owner[i] = w;
        held[i]  = 1;
        last[i]  = w;
      end
    end else if (r[owner[i]] && held[i] < mh[i]) begin
      held[i]++;
    end else begin
      ptr[i] = (owner[i] + 1) % 8;
      w = first_req(r, ptr[i]);
      if (w >= 0) begin
        owner[i] = w;
        held[i]  = 1;
        last[i]  = w;
      end else begin
        owner[i] = -1;
      end
    end
  endtask

  function automatic exp_t expect_of(input int i);
    exp_t e;
    e.sel  = 3'(last[i]);
    e.gnt  = (owner[i] >= 0) ? (8'd1 << owner[i]) : 8'd0;
    e.gv   = (owner[i] >= 0);
    e.hold = (owner[i] >= 0) ? 4'(held[i] - 1) : 4'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e, input logic [2:0] s, input logic [7:0] g,
                     input logic v, input logic [3:0] h);
    vectors++;
    if (s !== e.sel || g !== e.gnt || v !== e.gv || h !== e.hold) begin
      miscompares++;
      $display("FAIL %s @%0t: got sel=%0d gnt=%h gv=%b hold=%0d, want sel=%0d gnt=%h gv=%b hold=%0d",
               nm, $time, s, g, v, h, e.sel, e.gnt, e.gv, e.hold);
    end
  endtask

  // Monitor: one expected response per instance per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("hold4", e, sel0, gnt0, gv0, hc0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("hold1", e, sel1, gnt1, gv1, hc1);
      end
    end
  end

  task automatic step(input logic [7:0] r);
    @(posedge clk);
    #2;
    req = r;
    model_edge(0, r);
    model_edge(1, r);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    exp_t z;
    z.sel = 3'd0; z.gnt = 8'd0; z.gv = 1'b0; z.hold = 4'd0;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk("reset0", z, sel0, gnt0, gv0, hc0);
    chk("reset1", z, sel1, gnt1, gv1, hc1);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    mh[0] = 4;
    mh[1] = 1;
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    do_reset();

    repeat (5) step(8'h00);

    do_reset();
    repeat (12) step(8'h24);

    do_reset();
    repeat (10) step(8'h08);

    do_reset();
    step(8'h80);
    step(8'h81);
    step(8'h81);
    step(8'h01);
    step(8'h01);

    do_reset();
    step(8'h02);
    step(8'h02);
    step(8'h00);
    step(8'h00);
    step(8'h03);
    step(8'h03);

    do_reset();
    repeat (3) step(8'h40);
    do_reset();
    repeat (4) step(8'hFF);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: r = 8'd1 << $urandom_range(0, 7);
        default: r = req;
      endcase
      step(r);
    end

    repeat (2) @(posedge clk);
    #3;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: req[i]=1 means requester i wants the 8:1 mux path.
REQ-005 The block SHALL have port sel, output, 3 bits: registered select driven to the 8:1 mux S input.
REQ-006 The block SHALL have port gnt, output, 8 bits: registered one-hot grant, gnt[sel]=1 while granted, else all zero.
REQ-007 The block SHALL have port gnt_valid, output, 1 bit: 1 while any grant is active (equals OR of gnt).
REQ-008 The block SHALL have port hold_cnt, output, 4 bits: cycles the current owner has held the grant, minus 1.

Function
REQ-009 The block SHALL implement a two-state FSM, IDLE (no grant) and GRANT (one owner).
REQ-010 The block SHALL keep an internal 3-bit round-robin pointer ptr; the search order is ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-011 In IDLE with req!=0 the block SHALL select the first set req bit in search order, load sel with its index, set gnt to its one-hot code, clear hold_cnt, and enter GRANT at the next edge (grant latency 1 cycle from req sampled).
REQ-012 In IDLE with req==0 the block SHALL stay in IDLE with gnt=0 and gnt_valid=0, and sel SHALL keep its last value.
REQ-013 In GRANT the owner SHALL retain the grant while req[sel]=1 and hold_cnt < MAX_HOLD-1; hold_cnt SHALL increment by 1 each such cycle.
REQ-014 A release event SHALL occur when req[sel]=0 (owner drop) or when req[sel]=1 and hold_cnt == MAX_HOLD-1 (expiry).
REQ-015 On a release event ptr SHALL become sel+1 (wrapping 7->0).
REQ-016 On a release event the block SHALL re-arbitrate in the same cycle with the new ptr, excluding no one, so the next owner is granted at the following edge with no idle bubble.
REQ-017 On expiry with no other requester active, the same owner SHALL be re-granted with hold_cnt cleared to 0.
REQ-018 On owner drop with req==0, the block SHALL go to IDLE at the next edge with gnt=0 and sel unchanged.
REQ-019 Requests from non-owners during GRANT SHALL NOT affect sel or gnt until a release event.
REQ-020 gnt SHALL never have more than one bit set, and sel SHALL change only on edges where gnt changes.
REQ-021 With MAX_HOLD=1, every granted cycle SHALL be an expiry; a continuously requesting set SHALL rotate one requester per cycle.
REQ-022 The block SHALL NOT perform any combinational path from req to sel, gnt, gnt_valid or hold_cnt.

Reset
REQ-023 When rst_n=0 the block SHALL asynchronously force state=IDLE, sel=0, gnt=0, gnt_valid=0, hold_cnt=0 and ptr=0, independent of clk.
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately, and no history SHALL be retained.
REQ-025 After rst_n rises, the first arbitration SHALL start from ptr=0.

Verification
REQ-026 Scenario 1: reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, sel=0 throughout.
REQ-027 Scenario 2: req=8'h24 held, MAX_HOLD=4 -> owner 2 for 4 cycles (hold_cnt 0..3), then owner 5 for 4 cycles, then owner 2, with no gap cycles.
REQ-028 Scenario 3: req=8'h08 only, held 10 cycles -> sel=3 continuously, hold_cnt sequence 0,1,2,3,0,1,2,3,0,1.
REQ-029 Scenario 4: owner 7 drops req while req[0]=1 -> next edge sel=0, gnt=8'h01, hold_cnt=0 (wrap-around).
REQ-030 Scenario 5: owner 1 drops req and req becomes 0 -> next edge gnt=0, gnt_valid=0, sel stays 1; a later req=8'h03 grants 2? no requester 2, so owner 0 wins? -> owner SHALL be 0 only if ptr search 2..7,0 finds it first: expected sel=0.
REQ-031 Scenario 6: rst_n pulsed low mid-grant (sel=6) between clock edges -> gnt=0, sel=0 immediately; after release with req=8'hFF, first grant is sel=0.
